// File: rtl/rx_buf_pkg.sv
// Shared types for the ping-pong sample buffer controller.
package rx_buf_pkg;

  localparam int unsigned OVF_CNT_W = 16;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankReading
  } bank_state_e;

  typedef enum logic {
    WrFill,
    WrDrop
  } wr_state_e;

endpackage

// File: rtl/rx_sample_buffer_ctrl_if.sv
// Signal bundle between the buffer controller (slave) and its environment (master):
// receiver input stage, frame consumer and the single-port sample RAM.
interface rx_sample_buffer_ctrl_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 256
);
  import rx_buf_pkg::*;

  localparam int unsigned OFS_W = $clog2(FRAME_LEN);

  logic                 in_en;
  logic [DATA_W-1:0]    in_data;
  logic                 frame_ready;
  logic                 frame_bank;
  logic                 frame_ack;
  logic                 frame_done;
  logic                 rd_req;
  logic [OFS_W-1:0]     rd_ofs;
  logic                 rd_stall;
  logic                 rd_valid;
  logic [DATA_W-1:0]    rd_data;
  logic                 mem_en;
  logic                 mem_we;
  logic [OFS_W:0]       mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 overflow;
  logic [OVF_CNT_W-1:0] ovf_count;

  modport slave (
    input  in_en, in_data, frame_ack, frame_done, rd_req, rd_ofs, mem_rdata,
    output frame_ready, frame_bank, rd_stall, rd_valid, rd_data,
           mem_en, mem_we, mem_addr, mem_wdata, overflow, ovf_count
  );

  modport master (
    output in_en, in_data, frame_ack, frame_done, rd_req, rd_ofs, mem_rdata,
    input  frame_ready, frame_bank, rd_stall, rd_valid, rd_data,
           mem_en, mem_we, mem_addr, mem_wdata, overflow, ovf_count
  );

endinterface

// File: rtl/rx_port_arb.sv
// Single RAM port mux: the writer always wins, reads are granted only on idle write cycles.
module rx_port_arb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OFS_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_en_i,
  input  logic              wr_en_i,
  input  logic              wr_bank_i,
  input  logic [OFS_W-1:0]  wr_ofs_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_req_i,
  input  logic              rd_allow_i,
  input  logic              rd_bank_i,
  input  logic [OFS_W-1:0]  rd_ofs_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [OFS_W:0]    mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              rd_stall_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic rd_grant;
  logic rd_valid_q;

  // A strobe from the input stage blocks the read even when the writer drops it.
  assign rd_grant   = rd_req_i & rd_allow_i & ~in_en_i;
  assign rd_stall_o = rd_req_i & ~rd_grant;

  always_comb begin
    mem_en_o    = wr_en_i | rd_grant;
    mem_we_o    = wr_en_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (wr_en_i) begin
      mem_addr_o  = {wr_bank_i, wr_ofs_i};
      mem_wdata_o = wr_data_i;
    end else if (rd_grant) begin
      mem_addr_o  = {rd_bank_i, rd_ofs_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_grant;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_valid_q ? mem_rdata_i : '0;

endmodule

// File: rtl/rx_sample_buffer_ctrl.sv
// Ping-pong RX sample buffer controller over a single-port RAM of two FRAME_LEN banks.
// Define RX_OVF_COUNT_EN to build the saturating dropped-sample counter.
module rx_sample_buffer_ctrl
  import rx_buf_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rx_sample_buffer_ctrl_if.slave bus_io
);

  localparam int unsigned OFS_W = $clog2(FRAME_LEN);
  localparam logic [OFS_W-1:0] LastOfs = OFS_W'(FRAME_LEN - 1);

  bank_state_e      bank_q [2];
  bank_state_e      bank_d [2];
  wr_state_e        wstate_q, wstate_d;
  logic             wbank_q, wbank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [OFS_W-1:0] wofs_q, wofs_d;
  logic             overflow_q;
  logic             frame_ready, reading, ack, rel, wr_en, drop, other_free;

  // Banks complete and are consumed in the same alternating order, so the oldest FULL
  // bank is always the one after the last released bank.
  assign frame_ready = (bank_q[rd_bank_q] == BankFull);
  assign reading     = (bank_q[rd_bank_q] == BankReading);
  assign ack         = bus_io.frame_ack & frame_ready;
  assign rel         = bus_io.frame_done & reading;
  assign wr_en       = bus_io.in_en & (wstate_q == WrFill);
  assign drop        = bus_io.in_en & (wstate_q == WrDrop);
  assign other_free  = (bank_q[~wbank_q] == BankEmpty) | (rel & (rd_bank_q == ~wbank_q));

  always_comb begin
    bank_d    = bank_q;
    wstate_d  = wstate_q;
    wbank_d   = wbank_q;
    wofs_d    = wofs_q;
    rd_bank_d = rd_bank_q;
    if (ack) begin
      bank_d[rd_bank_q] = BankReading;
    end
    if (rel) begin
      bank_d[rd_bank_q] = BankEmpty;
      rd_bank_d         = ~rd_bank_q;
    end
    if (wr_en) begin
      wofs_d = wofs_q + OFS_W'(1);
      if (wofs_q == LastOfs) begin
        bank_d[wbank_q] = BankFull;
        wbank_d         = ~wbank_q;
        wstate_d        = other_free ? WrFill : WrDrop;
      end else begin
        bank_d[wbank_q] = BankFilling;
      end
    end else if ((wstate_q == WrDrop) && rel && (rd_bank_q == wbank_q)) begin
      wstate_d = WrFill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]  <= BankEmpty;
      bank_q[1]  <= BankEmpty;
      wstate_q   <= WrFill;
      wbank_q    <= 1'b0;
      wofs_q     <= '0;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wstate_q   <= wstate_d;
      wbank_q    <= wbank_d;
      wofs_q     <= wofs_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_q | drop;
    end
  end

  assign bus_io.frame_ready = frame_ready;
  assign bus_io.frame_bank  = rd_bank_q;
  assign bus_io.overflow    = overflow_q;

`ifdef RX_OVF_COUNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
    end
  end

  assign bus_io.ovf_count = ovf_cnt_q;
`else
  assign bus_io.ovf_count = '0;
`endif

  rx_port_arb #(
    .DATA_W(DATA_W),
    .OFS_W (OFS_W)
  ) u_port_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_en_i    (bus_io.in_en),
    .wr_en_i    (wr_en),
    .wr_bank_i  (wbank_q),
    .wr_ofs_i   (wofs_q),
    .wr_data_i  (bus_io.in_data),
    .rd_req_i   (bus_io.rd_req),
    .rd_allow_i (reading),
    .rd_bank_i  (rd_bank_q),
    .rd_ofs_i   (bus_io.rd_ofs),
    .mem_rdata_i(bus_io.mem_rdata),
    .mem_en_o   (bus_io.mem_en),
    .mem_we_o   (bus_io.mem_we),
    .mem_addr_o (bus_io.mem_addr),
    .mem_wdata_o(bus_io.mem_wdata),
    .rd_stall_o (bus_io.rd_stall),
    .rd_valid_o (bus_io.rd_valid),
    .rd_data_o  (bus_io.rd_data)
  );

endmodule

// File: tb/tb_rx_sample_buffer_ctrl.sv
// Directed bench for rx_sample_buffer_ctrl with FRAME_LEN=8 and a behavioural sample RAM.
module tb_rx_sample_buffer_ctrl;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAME_LEN = 8;
`ifdef RX_OVF_COUNT_EN
  localparam int unsigned ExpOvf1 = 1;
  localparam int unsigned ExpOvf2 = 2;
`else
  localparam int unsigned ExpOvf1 = 0;
  localparam int unsigned ExpOvf2 = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  rx_sample_buffer_ctrl_if #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) bus ();

  rx_sample_buffer_ctrl #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_en = 1'b0; bus.in_data = '0; bus.frame_ack = 1'b0; bus.frame_done = 1'b0;
    bus.rd_req = 1'b0; bus.rd_ofs = '0; bus.mem_rdata = '0;

    next_cycle(); #1;
    check_eq("rst_frame_ready", bus.frame_ready, 0);
    check_eq("rst_mem_en", bus.mem_en, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_overflow", bus.overflow, 0);
    check_eq("rst_ovf_count", bus.ovf_count, 0);
    next_cycle(); rst_n = 1'b1;

    // Fill bank 0 with samples 0..7.
    for (int i = 0; i < 8; i++) begin
      next_cycle(); bus.in_en = 1'b1; bus.in_data = 16'hA000 + 16'(i); #1;
      check_eq($sformatf("fill0_addr%0d", i), bus.mem_addr, i);
      check_eq($sformatf("fill0_we%0d", i), bus.mem_we, 1);
      check_eq($sformatf("fill0_wdata%0d", i), bus.mem_wdata, 32'hA000 + i);
      if (i == 7) check_eq("fill0_not_ready_yet", bus.frame_ready, 0);
    end
    next_cycle(); bus.in_en = 1'b0; #1;
    check_eq("bank0_ready", bus.frame_ready, 1);
    check_eq("bank0_offer", bus.frame_bank, 0);
    next_cycle(); bus.in_en = 1'b1; bus.in_data = 16'hA008; #1;
    check_eq("sample8_addr", bus.mem_addr, 8);

    // Claim bank 0 and read it back.
    next_cycle(); bus.in_en = 1'b0; bus.frame_ack = 1'b1;
    next_cycle(); bus.frame_ack = 1'b0; #1;
    check_eq("ack0_ready_drop", bus.frame_ready, 0);
    check_eq("ack0_bank", bus.frame_bank, 0);
    for (int i = 0; i < 8; i++) begin
      next_cycle(); bus.rd_req = 1'b1; bus.rd_ofs = 3'(i); #1;
      check_eq($sformatf("rd0_stall%0d", i), bus.rd_stall, 0);
      check_eq($sformatf("rd0_addr%0d", i), {bus.mem_en, bus.mem_we, bus.mem_addr}, 32'h20 + i);
      check_eq($sformatf("rd0_valid_early%0d", i), bus.rd_valid, 0);
      next_cycle(); bus.rd_req = 1'b0; #1;
      check_eq($sformatf("rd0_valid%0d", i), bus.rd_valid, 1);
      check_eq($sformatf("rd0_data%0d", i), bus.rd_data, 32'hA000 + i);
    end
    next_cycle(); bus.frame_done = 1'b1;
    next_cycle(); bus.frame_done = 1'b0;

    // Complete bank 1 (samples 9..15); bank 0 is free so the writer wraps into it.
    for (int n = 9; n < 16; n++) begin
      next_cycle(); bus.in_en = 1'b1; bus.in_data = 16'hA000 + 16'(n); #1;
      check_eq($sformatf("fill1_addr%0d", n), bus.mem_addr, n);
    end
    next_cycle(); bus.in_en = 1'b0; #1;
    check_eq("bank1_ready", bus.frame_ready, 1);
    check_eq("bank1_offer", bus.frame_bank, 1);
    next_cycle(); bus.frame_ack = 1'b1;
    next_cycle(); bus.frame_ack = 1'b0; #1;
    check_eq("ack1_ready_drop", bus.frame_ready, 0);
    check_eq("ack1_bank", bus.frame_bank, 1);

    // Read held across three writes.
    for (int k = 0; k < 3; k++) begin
      next_cycle(); bus.in_en = 1'b1; bus.in_data = 16'hA010 + 16'(k);
      bus.rd_req = 1'b1; bus.rd_ofs = 3'd2; #1;
      check_eq($sformatf("stall%0d", k), bus.rd_stall, 1);
      check_eq($sformatf("stall_wr%0d", k), {bus.mem_en, bus.mem_we, bus.mem_addr}, 32'h30 + k);
    end
    next_cycle(); bus.in_en = 1'b0; #1;
    check_eq("stall_released", bus.rd_stall, 0);
    check_eq("stall_rd_addr", {bus.mem_en, bus.mem_we, bus.mem_addr}, 32'h2A);
    next_cycle(); bus.rd_req = 1'b0; #1;
    check_eq("stall_rd_valid", bus.rd_valid, 1);
    check_eq("stall_rd_data", bus.rd_data, 32'hA00A);
    next_cycle(); bus.frame_done = 1'b1;
    next_cycle(); bus.frame_done = 1'b0;

    next_cycle(); rst_n = 1'b0;
    next_cycle(); rst_n = 1'b1;

    // Overflow: 17 samples with no consumer.
    for (int n = 0; n < 16; n++) begin
      next_cycle(); bus.in_en = 1'b1; bus.in_data = 16'hB000 + 16'(n); #1;
      check_eq($sformatf("ovf_fill_addr%0d", n), bus.mem_addr, n);
    end
    next_cycle(); bus.in_data = 16'hB010; #1;
    check_eq("drop16_no_mem", bus.mem_en, 0);
    check_eq("drop16_ovf_not_yet", bus.overflow, 0);
    next_cycle(); bus.in_en = 1'b0; #1;
    check_eq("overflow_set", bus.overflow, 1);
    check_eq("ovf_count1", bus.ovf_count, ExpOvf1);
    check_eq("drop_ready", bus.frame_ready, 1);
    check_eq("drop_offer", bus.frame_bank, 0);

    // Release bank 0 while dropping; the sample alongside frame_done is lost.
    next_cycle(); bus.frame_ack = 1'b1;
    next_cycle(); bus.frame_ack = 1'b0; bus.frame_done = 1'b1;
    bus.in_en = 1'b1; bus.in_data = 16'hB111; #1;
    check_eq("done_cycle_dropped", bus.mem_en, 0);
    next_cycle(); bus.frame_done = 1'b0; bus.in_data = 16'hB100; #1;
    check_eq("resume_wr", {bus.mem_en, bus.mem_we, bus.mem_addr}, 32'h30);
    check_eq("resume_wdata", bus.mem_wdata, 32'hB100);
    check_eq("ovf_count2", bus.ovf_count, ExpOvf2);
    check_eq("resume_ready", bus.frame_ready, 1);
    check_eq("resume_offer", bus.frame_bank, 1);

    // Bank 1 READING, writer at offset 5, then async reset.
    next_cycle(); bus.in_en = 1'b0; bus.frame_ack = 1'b1;
    next_cycle(); bus.frame_ack = 1'b0;
    for (int k = 1; k < 5; k++) begin
      next_cycle(); bus.in_en = 1'b1; bus.in_data = 16'hB200 + 16'(k); #1;
      check_eq($sformatf("mid_addr%0d", k), bus.mem_addr, k);
    end
    next_cycle(); bus.in_en = 1'b0; bus.rd_req = 1'b1; bus.rd_ofs = 3'd3; #1;
    check_eq("mid_rd_addr", {bus.mem_en, bus.mem_we, bus.mem_addr}, 32'h2B);
    next_cycle(); bus.rd_req = 1'b0; #1;
    check_eq("mid_rd_data", bus.rd_data, 32'hB00B);
    check_eq("mid_bank", bus.frame_bank, 1);
    #1 rst_n = 1'b0; #1;
    check_eq("async_rd_valid", bus.rd_valid, 0);
    check_eq("async_rd_data", bus.rd_data, 0);
    check_eq("async_overflow", bus.overflow, 0);
    check_eq("async_ovf_count", bus.ovf_count, 0);
    check_eq("async_frame_bank", bus.frame_bank, 0);
    next_cycle(); rst_n = 1'b1;
    next_cycle(); bus.in_en = 1'b1; bus.in_data = 16'hB300; #1;
    check_eq("post_rst_wr", {bus.mem_en, bus.mem_we, bus.mem_addr}, 32'h30);
    next_cycle(); bus.in_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_sample_buffer_ctrl.md
Name: rx_sample_buffer_ctrl

Overview:
- Ping-pong buffer controller that sits between the receiver input stage and a single-port sample RAM (two banks of FRAME_LEN words).
- Sequences the write stream into alternating banks and hands each completed frame to a downstream consumer.
- Shares the single RAM port between the real-time writer and the consumer's reads.
- Writer has absolute priority; the consumer stalls whenever a write occupies the port.

Parameters:
- DATA_W, 16, sample width.
- FRAME_LEN, 256, samples per bank; power of two, ≥4.
- OFS_W, $clog2(FRAME_LEN), offset width inside a bank (derived, not overridden).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- in_en  in  1  sample strobe from the receiver input stage (its write_en).
- in_data  in  DATA_W  sample from the receiver input stage (its write_data).
- frame_ready  out  1  a FULL bank awaits the consumer.
- frame_bank  out  1  bank index offered or owned by the consumer.
- frame_ack  in  1  consumer claims the offered bank; honoured only while frame_ready=1.
- frame_done  in  1  consumer releases its owned bank.
- rd_req  in  1  read request within the owned bank.
- rd_ofs  in  OFS_W  read offset.
- rd_stall  out  1  rd_req not granted this cycle (combinational).
- rd_valid  out  1  rd_data valid.
- rd_data  out  DATA_W  read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  OFS_W+1  {bank, offset}.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous, 1-cycle latency.
- overflow  out  1  sticky: a sample was dropped.
- ovf_count  out  16  dropped-sample count (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; both banks EMPTY; writer in bank 0, offset 0, state FILL. Async assert; deassert is sampled on clk.
- Per-bank state: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
- Writer FSM, FILL state:
  - in_en writes in_data to {wbank, wofs} in the same cycle (mem_en=mem_we=1); wofs increments.
  - On the write with wofs=FRAME_LEN-1, bank -> FULL and wofs wraps to 0.
  - If the other bank is EMPTY: wbank toggles and the writer stays in FILL. Otherwise the writer goes to DROP.
- Writer FSM, DROP state:
  - in_en is discarded; overflow is set (sticky until reset).
  - When the target bank becomes EMPTY, the writer returns to FILL. The first in_en in the cycle after the release is written.
  - A frame_done and an in_en in the same cycle: that sample is dropped.
- Consumer offer/claim:
  - frame_ready=1 whenever any bank is FULL and no bank is READING. frame_bank points to the oldest FULL bank.
  - frame_ack moves that bank to READING; frame_ready drops the next cycle.
  - frame_ack while frame_ready=0 is ignored.
- Reads:
  - Allowed only while a bank is READING; rd_req otherwise is ignored (no rd_valid).
  - Grant when rd_req=1 and in_en=0: mem_en=1, mem_we=0, mem_addr={frame_bank, rd_ofs}.
  - rd_valid=1 exactly one cycle after the grant, with rd_data=mem_rdata.
  - rd_req and in_en together: rd_stall=1, write proceeds, consumer holds rd_req/rd_ofs.
- Release: frame_done while READING -> bank EMPTY next cycle. frame_done otherwise is ignored.
- Simultaneous frame_ack and frame_done: frame_done applies to the current READING bank; frame_ack is ignored (frame_ready is already 0).

Optional Feature:
- Macro RX_OVF_COUNT_EN.
- Defined: ovf_count increments on every dropped in_en and saturates at 16'hFFFF; cleared only by reset.
- Undefined: ovf_count is tied to 0 and no counter logic is built; overflow behaves identically in both builds.

Decomposition:
- Package rx_buf_pkg holds:
  - bank-state enum (EMPTY, FILLING, FULL, READING);
  - writer-state enum (FILL, DROP);
  - OVF_CNT_W=16 constant.
- One natural sub-module: rx_port_arb, the combinational writer-priority mux producing mem_*, rd_stall and the grant, plus the rd_valid delay flop.

Test Plan (FRAME_LEN=8):
- 8 in_en with data 0..7 -> mem writes to addr 0..7, frame_ready=1 with frame_bank=0; next sample goes to addr 8.
- frame_ack, then rd_req at ofs 0..7 with in_en idle -> rd_valid one cycle after each request, rd_data=0..7; frame_done -> bank 0 EMPTY.
- rd_req held for 3 cycles while in_en=1 each cycle -> rd_stall=1 for 3 cycles, 3 writes land, read completes on the 4th cycle.
- 17 samples with no consumer -> banks 0 and 1 FULL, sample 16 dropped, overflow=1, ovf_count=1 (RX_OVF_COUNT_EN defined; 0 when undefined).
- In DROP: frame_ack then frame_done on bank 0; next in_en is written at addr 0.
- rst_n pulsed low mid-frame (wofs=5, bank 1 READING) -> all outputs 0 immediately; the next sample is written to addr 0.
